// File: rtl/bkm_shift_add_if.sv
// Handshake and data bundle between the BKM digit-selection logic and the
// shift-and-add datapath.
interface bkm_shift_add_if #(
  parameter int W = 16,
  parameter int N = W - 1
);
  logic                ena;
  logic                start;
  logic signed [W-1:0] x_in;
  logic [2*N-1:0]      d_in;
  logic                busy;
  logic                done;
  logic signed [W-1:0] x_out;
  logic                ovf;

  modport master (output ena, start, x_in, d_in, input busy, done, x_out, ovf);
  modport slave  (input ena, start, x_in, d_in, output busy, done, x_out, ovf);
endinterface

// File: rtl/bkm_shift_add.sv
// Iterative BKM shift-and-add datapath: x(n+1) = x(n) + d(n)*(x(n) >>> n),
// one iteration per enabled clock, result handed to the FPU normaliser.
module add_subb #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         subb_a,
  input  logic         subb_b,
  output logic [W-1:0] sum,
  output logic         carry
);
  logic [W:0] w_s;

  // Each negated operand is ones-complemented and gets its +1 via a carry-in.
  assign w_s = {1'b0, a ^ {W{subb_a}}} + {1'b0, b ^ {W{subb_b}}}
             + {{W{1'b0}}, subb_a} + {{W{1'b0}}, subb_b};
  assign {carry, sum} = w_s;
endmodule

module bkm_shift_add #(
  parameter int W = 16,
  parameter int N = W - 1
) (
  input  logic           clk,
  input  logic           rst_n,
  bkm_shift_add_if.slave bus
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic signed [W-1:0] r_x, r_xout;
  logic [2*N-1:0]      r_d;
  logic                r_ovf;

  logic [1:0]          w_dig;
  logic                w_add, w_sub, w_upd, w_last, w_accept, w_ovf;
  logic signed [W-1:0] w_sh;
  logic [W-1:0]        w_sum;
  logic                w_carry_unused;

  // Digits are consumed from the bottom of r_d, which shifts down two bits per iteration.
  assign w_dig    = r_d[1:0];
  assign w_add    = (w_dig == 2'b01);
  assign w_sub    = (w_dig == 2'b11);
  assign w_upd    = w_add | w_sub;
  assign w_last   = (r_cnt == CW'(N - 1));
  assign w_accept = bus.start && (r_state != S_RUN);
  assign w_sh     = r_x >>> r_cnt;

  add_subb #(.W(W)) u_add_subb (
    .a      (r_x),
    .b      (w_sh),
    .subb_a (1'b0),
    .subb_b (w_sub),
    .sum    (w_sum),
    .carry  (w_carry_unused)
  );

  always_comb begin
    w_ovf = 1'b0;
    if (w_add)
      w_ovf = (r_x[W-1] == w_sh[W-1]) && (w_sum[W-1] != r_x[W-1]);
    else if (w_sub)
      w_ovf = (r_x[W-1] != w_sh[W-1]) && (w_sum[W-1] != r_x[W-1]);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_state <= S_IDLE;
    else if (bus.ena) r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_x    <= '0;
      r_d    <= '0;
      r_xout <= '0;
      r_ovf  <= 1'b0;
    end else if (bus.ena) begin
      if (w_accept) begin
        r_x   <= bus.x_in;
        r_d   <= bus.d_in;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (r_state == S_RUN) begin
        if (w_upd)         r_x   <= w_sum;
        if (w_upd && w_ovf) r_ovf <= 1'b1;
        r_d   <= r_d >> 2;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) r_xout <= w_upd ? w_sum : r_x;
      end
    end
  end

  assign bus.busy  = (r_state == S_RUN);
  assign bus.done  = (r_state == S_DONE);
  assign bus.x_out = r_xout;
  assign bus.ovf   = r_ovf;
endmodule

// File: tb/tb_bkm_shift_add.sv
// Directed and randomized bench for bkm_shift_add (W=8, N=7) against an
// integer-arithmetic model of the BKM recurrence.
module tb_bkm_shift_add;
  localparam int W = 8;
  localparam int N = 7;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  bkm_shift_add_if #(.W(W), .N(N)) bus ();
  bkm_shift_add #(.W(W), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Exact integer recurrence; overflow means the true result left the W-bit range.
  function automatic void model(input int x0, input logic [2*N-1:0] d, output int xr, output bit ov);
    int x, s, t;
    logic [1:0] code;
    x  = x0;
    ov = 1'b0;
    for (int n = 0; n < N; n++) begin
      code = d[2*n +: 2];
      s = x >>> n;
      t = x;
      if (code == 2'b01) t = x + s;
      else if (code == 2'b11) t = x - s;
      if (t > 127 || t < -128) ov = 1'b1;
      x = ((t + 128) & 255) - 128;
    end
    xr = x;
  endfunction

  task automatic launch(input int x, input logic [2*N-1:0] d);
    bus.start = 1'b1;
    bus.x_in  = W'(x);
    bus.d_in  = d;
  endtask

  task automatic wait_done(input string tag, input int exp_x, input bit exp_ovf,
                           input int stall_at, input int stall_len, input bit mid_start);
    int cnt  = 0;
    int nbsy = 0;
    bit seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "/done0"}, int'(bus.done), 0);
    while (!seen && cnt < 60) begin
      if (bus.done === 1'b1) seen = 1'b1;
      if (bus.busy === 1'b1) nbsy++;
      bus.ena = !(cnt >= stall_at && cnt < stall_at + stall_len);
      if (mid_start && cnt == 1) begin
        bus.start = 1'b1; bus.x_in = 8'sd5; bus.d_in = 14'h0001;
      end else if (mid_start && cnt == 2) begin
        bus.start = 1'b0;
      end
      if (!seen) begin
        @(negedge clk);
        cnt++;
      end
    end
    bus.ena = 1'b1;
    chk({tag, "/seen"}, int'(seen), 1);
    chk({tag, "/lat"},  cnt,  N + stall_len);
    chk({tag, "/busy"}, nbsy, N + stall_len);
    chk({tag, "/x"},    bus.x_out, exp_x);
    chk({tag, "/ovf"},  int'(bus.ovf), int'(exp_ovf));
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, "/pulse"}, int'(bus.done), 0);
    chk({tag, "/idle"},  int'(bus.busy), 0);
  endtask

  initial begin
    int  xr, xs, sa, sl;
    bit  ov, b2b;
    logic [2*N-1:0] dr;

    rst_n     = 1'b0;
    bus.ena   = 1'b1;
    bus.start = 1'b0;
    bus.x_in  = '0;
    bus.d_in  = '0;
    #3;
    chk("rst/busy", int'(bus.busy), 0);
    chk("rst/done", int'(bus.done), 0);
    chk("rst/ovf",  int'(bus.ovf),  0);
    chk("rst/x",    bus.x_out,      0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Plan 1, then ena low during the done cycle keeps the pulse up.
    launch(16, 14'h0000);
    wait_done("p1", 16, 1'b0, 99, 0, 1'b0);
    bus.ena = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("p1/hold", int'(bus.done), 1);
    end
    bus.ena = 1'b1;
    idle_chk("p1");

    launch(16, 14'h0034);
    wait_done("p2", 18, 1'b0, 99, 0, 1'b0);
    idle_chk("p2");

    launch(100, 14'h0001);
    wait_done("p3", -56, 1'b1, 99, 0, 1'b0);
    idle_chk("p3");
    launch(1, 14'h0000);
    wait_done("p3b", 1, 1'b0, 99, 0, 1'b0);
    idle_chk("p3b");

    launch(-64, 14'h0040);
    wait_done("p4", -72, 1'b0, 99, 0, 1'b0);
    idle_chk("p4");
    launch(-64, 14'h0080);
    wait_done("p4b", -64, 1'b0, 99, 0, 1'b0);
    idle_chk("p4b");

    // Stall, ignored mid-run start, then back-to-back launch from the done cycle.
    launch(16, 14'h0034);
    wait_done("p5", 18, 1'b0, 3, 3, 1'b1);
    launch(16, 14'h0000);
    wait_done("p5b", 16, 1'b0, 99, 0, 1'b0);
    idle_chk("p5b");

    // Asynchronous reset between edges while a run has already flagged overflow.
    launch(100, 14'h0001);
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    chk("p6/pre_ovf",  int'(bus.ovf),  1);
    chk("p6/pre_busy", int'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("p6/busy", int'(bus.busy), 0);
    chk("p6/done", int'(bus.done), 0);
    chk("p6/ovf",  int'(bus.ovf),  0);
    chk("p6/x",    bus.x_out,      0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("p6/quiet_busy", int'(bus.busy), 0);
    chk("p6/quiet_done", int'(bus.done), 0);
    launch(16, 14'h0034);
    wait_done("p6r", 18, 1'b0, 99, 0, 1'b0);
    idle_chk("p6r");

    // Random operands and digits, random stalls and back-to-back launches.
    for (int i = 0; i < 30; i++) begin
      xs  = int'($urandom_range(0, 255)) - 128;
      dr  = 14'($urandom);
      sl  = int'($urandom_range(0, 2));
      sa  = int'($urandom_range(0, 6));
      b2b = 1'($urandom);
      model(xs, dr, xr, ov);
      launch(xs, dr);
      wait_done($sformatf("rnd%0d", i), xr, ov, sa, sl, 1'b0);
      if (!b2b) idle_chk($sformatf("rnd%0d", i));
    end
    idle_chk("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bkm_shift_add.md
Name: bkm_shift_add

Overview:
- Iterative shift-and-add datapath. Executes the BKM-style recurrence x(n+1) = x(n) + d(n)*(x(n) >>> n) for n = 0..N-1.
- Drives an internal add_subb instance every iteration and registers its sum output back into the working register.
- Sits between the BKM digit-selection logic, which supplies d(n), and the downstream FPU normalisation stage, which consumes x_out.

Parameters:
- W, 16, datapath width in bits (signed two's complement).
- N, W-1, number of iterations; legal range 1..W-1.
- CW, $clog2(N)+1, iteration counter width (derived; do not override).

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- ena, input, 1, clock enable; when low, all state is frozen.
- start, input, 1, request a new computation; sampled when ena=1.
- x_in, input, W, signed initial value x(0).
- d_in, input, 2N, packed digits; bits [2n+1:2n] hold d(n).
- busy, output, 1, high while in RUN.
- done, output, 1, one-cycle pulse when x_out is updated.
- x_out, output, W, signed result x(N); held until the next completion.
- ovf, output, 1, sticky signed-overflow flag for the current or last computation.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, working register=0, x_out=0, busy=0, done=0, ovf=0. Takes effect immediately, including mid-run. Leaving reset requires a new start.
- Digit code per iteration: 00 -> d=0 (x held); 01 -> d=+1 (add); 11 -> d=-1 (subtract); 10 -> illegal, treated as d=0.
- add_subb hookup:
  - subb_a=0, subb_b=(d==-1).
  - a = working register; b = working register arithmetically shifted right by n (sign-extended).
  - For d=0 the register is not updated.
- Arithmetic: result wraps modulo 2^W; no saturation.
- Overflow: for add, overflow when a and b have equal signs and the sum's sign differs. For subtract, overflow when a and b have different signs and the result's sign differs from a. On overflow, ovf sets and stays set until the next accepted start. The add_subb carry output is unused.
- FSM, all transitions only on edges with ena=1:
  - IDLE: start=1 -> load x_in into the working register, capture d_in, counter=0, clear ovf, go to RUN.
  - RUN: each edge performs iteration n=counter, then counter+1. After the edge that performs n=N-1, go to DONE and copy the result into x_out.
  - DONE: done=1 for this cycle, then go to IDLE. A start here is accepted exactly as in IDLE, giving back-to-back operation with no idle cycle.
- Latency: start accepted at edge k -> iterations at edges k+1..k+N -> x_out valid and done=1 during the cycle following edge k+N (N+1 enabled edges after start).
- busy=1 exactly while in RUN. start while busy is ignored, with no queueing.
- d_in and x_in are captured at start; later changes do not affect the running computation.
- ena=0: FSM, counter, registers, and outputs all hold. A done pulse coincident with ena=0 stays high until the next ena=1 edge.
- N=1: a single iteration, so done appears 2 enabled edges after start.

Test Plan (W=8, N=7):
1. x_in=16, d_in all 00, start one cycle -> busy for 7 cycles; done pulse 8 edges after start; x_out=16; ovf=0.
2. x_in=16, d(1)=01, d(2)=11, other digits 00 -> 16+8=24, then 24-6=18; x_out=18; ovf=0.
3. x_in=100, d(0)=01, rest 00 -> 200 wraps to 8'b11001000; x_out=-56; ovf=1. Next start with x_in=1, all 00 -> ovf=0, x_out=1.
4. x_in=-64, d(3)=01 -> -64 + (-8) = -72; checks sign-extending shift; ovf=0. Repeat with d(3)=10 (illegal code) -> x_out=-64.
5. Scenario 2 with ena=0 for 3 cycles after iteration 3 -> done delayed exactly 3 cycles; x_out=18. A start pulse mid-run is ignored. A start during the done cycle launches the next run immediately.
6. Drop rst_n asynchronously mid-run (between edges) -> busy, done, ovf, x_out go to 0 immediately. After release, no activity until start; a new run then completes correctly.
